// File: rtl/poly_coeff_stream_mux_pkg.sv
// Shared Kyber constants, the stream FSM state type, and the signed
// small-coefficient to mod-Q expansion used by this mux and the adder/NTT paths.
package poly_coeff_stream_mux_pkg;

  localparam int KYBER_Q           = 3329;
  localparam int KYBER_N           = 256;
  localparam int KYBER_SPOLY_WIDTH = 3;
  localparam int KYBER_R_WIDTH     = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Two's-complement small coefficient -> canonical representative in [0,Q).
  // Negative values become Q+v. The sign extension makes the addition wrap
  // modulo 2^R_WIDTH, which leaves exactly Q+v.
  function automatic logic [KYBER_R_WIDTH-1:0] small_to_modq(
    input logic [KYBER_SPOLY_WIDTH-1:0] v
  );
    logic [KYBER_R_WIDTH-1:0] ext;
    ext = {{(KYBER_R_WIDTH-KYBER_SPOLY_WIDTH){v[KYBER_SPOLY_WIDTH-1]}}, v};
    if (v[KYBER_SPOLY_WIDTH-1]) return KYBER_R_WIDTH'(KYBER_Q) + ext;
    else                        return ext;
  endfunction

endpackage

// File: rtl/poly_coeff_stream_mux_if.sv
// Coefficient beat stream with a valid/ready handshake.
//   out_valid/out_data/out_beat/out_last : producer -> consumer
//   out_ready                            : consumer -> producer
interface poly_coeff_stream_mux_if #(
  parameter int LANES      = 16,
  parameter int COEF_WIDTH = 12,
  parameter int BEAT_W     = 4
);
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*COEF_WIDTH-1:0] out_data;
  logic [BEAT_W-1:0]           out_beat;
  logic                        out_last;

  modport master (output out_valid, out_data, out_beat, out_last, input  out_ready);
  modport slave  (input  out_valid, out_data, out_beat, out_last, output out_ready);
endinterface

// File: rtl/poly_coeff_stream_mux_small_coeff_expand.sv
// Combinational LANES-wide small-coefficient expander.
//   coef_i : LANES packed signed small coefficients (lane 0 in the LSBs)
//   coef_o : LANES mod-Q coefficients, same lane order
module small_coeff_expand
  import poly_coeff_stream_mux_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic [LANES*KYBER_SPOLY_WIDTH-1:0] coef_i,
  output logic [LANES*KYBER_R_WIDTH-1:0]     coef_o
);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign coef_o[l*KYBER_R_WIDTH +: KYBER_R_WIDTH] =
      small_to_modq(coef_i[l*KYBER_SPOLY_WIDTH +: KYBER_SPOLY_WIDTH]);
  end
endmodule

// File: rtl/poly_coeff_stream_mux.sv
// Selects one small (expanded to mod Q) or full polynomial and streams it
// out as LANES coefficients per beat.
//   clk, rst_n        : clock, async active-low reset
//   start, sel        : request + channel (small 0..NUM_SMALL-1, then full)
//   small_in, full_in : packed source polys, must be held stable while busy
//   strm              : beat stream (valid/ready/data/beat/last)
//   busy, done, err   : status; done/err are one-cycle pulses
module poly_coeff_stream_mux
  import poly_coeff_stream_mux_pkg::*;
#(
  parameter int N           = 256,
  parameter int Q           = 3329,
  parameter int SPOLY_WIDTH = 3,
  parameter int COEF_WIDTH  = 12,
  parameter int NUM_SMALL   = 4,
  parameter int NUM_FULL    = 1,
  parameter int LANES       = 16,
  parameter int SEL_W       = 3,
  localparam int BEATS      = N / LANES,
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [SEL_W-1:0]                    sel,
  input  logic [NUM_SMALL*N*SPOLY_WIDTH-1:0]  small_in,
  input  logic [NUM_FULL*N*COEF_WIDTH-1:0]    full_in,
  poly_coeff_stream_mux_if.master             strm,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  // The expander works at the package widths; reject mismatched builds.
  if (Q != KYBER_Q || SPOLY_WIDTH != KYBER_SPOLY_WIDTH ||
      COEF_WIDTH != KYBER_R_WIDTH || (N % LANES) != 0 ||
      (1 << SEL_W) < NUM_SMALL + NUM_FULL) begin : g_bad_cfg
    $error("poly_coeff_stream_mux: unsupported parameter set");
  end

  state_e                      state_q;
  logic [SEL_W-1:0]            sel_q;
  logic [BEAT_W-1:0]           beat_q;
  logic                        valid_q, last_q, busy_q, done_q, err_q;
  logic [LANES*COEF_WIDTH-1:0] data_q;

  // Which beat gets loaded into the output register at the next load:
  // beat 0 of the requested channel on start, else the following beat.
  logic [SEL_W-1:0]              sel_d;
  logic [BEAT_W-1:0]             beat_d;
  logic                          last_d, sel_ok;
  logic [LANES*SPOLY_WIDTH-1:0]  small_win;
  logic [LANES*COEF_WIDTH-1:0]   small_exp, full_win, data_d;

  assign sel_d  = (state_q == ST_IDLE) ? sel : sel_q;
  assign beat_d = (state_q == ST_IDLE) ? '0  : beat_q + 1'b1;
  assign last_d = (beat_d == BEAT_W'(BEATS-1));
  assign sel_ok = (int'(sel) < NUM_SMALL + NUM_FULL);

  always_comb begin
    small_win = '0;
    full_win  = '0;
    for (int c = 0; c < NUM_SMALL; c++)
      if (int'(sel_d) == c)
        small_win = small_in[c*N*SPOLY_WIDTH + int'(beat_d)*LANES*SPOLY_WIDTH +: LANES*SPOLY_WIDTH];
    for (int c = 0; c < NUM_FULL; c++)
      if (int'(sel_d) == NUM_SMALL + c)
        full_win = full_in[c*N*COEF_WIDTH + int'(beat_d)*LANES*COEF_WIDTH +: LANES*COEF_WIDTH];
  end

  small_coeff_expand #(.LANES(LANES)) u_expand (
    .coef_i (small_win),
    .coef_o (small_exp)
  );

  assign data_d = (int'(sel_d) < NUM_SMALL) ? small_exp : full_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (sel_ok) begin
              sel_q   <= sel;
              beat_q  <= beat_d;
              data_q  <= data_d;
              last_q  <= last_d;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_STREAM;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        // valid is always high here, so ready alone marks a handshake.
        ST_STREAM: begin
          if (strm.out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              beat_q <= beat_d;
              data_q <= data_d;
              last_q <= last_d;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign strm.out_valid = valid_q;
  assign strm.out_data  = data_q;
  assign strm.out_beat  = beat_q;
  assign strm.out_last  = last_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_poly_coeff_stream_mux.sv
module tb_poly_coeff_stream_mux;
  localparam int N = 256, LANES = 16, SW = 3, CW = 12, NS = 4, NF = 1;
  localparam int BEATS = 16, BW = 4, DW = LANES*CW;

  logic              clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [2:0]        sel = '0;
  logic [NS*N*SW-1:0] small_in;
  logic [NF*N*CW-1:0] full_in;
  logic              busy, done, err;

  poly_coeff_stream_mux_if #(.LANES(LANES), .COEF_WIDTH(CW), .BEAT_W(BW)) sif ();

  poly_coeff_stream_mux dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .small_in(small_in), .full_in(full_in), .strm(sif.master),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Hand-computed mod-3329 representatives of the 3-bit signed values.
  function automatic logic [CW-1:0] small_exp(input logic [2:0] v);
    case (v)
      3'd0: return 12'd0;
      3'd1: return 12'd1;
      3'd2: return 12'd2;
      3'd3: return 12'd3;
      3'd4: return 12'd3325;
      3'd5: return 12'd3326;
      3'd6: return 12'd3327;
      default: return 12'd3328;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_data(input int s, input int b);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      int i;
      i = b*LANES + l;
      if (s < NS) r[l*CW +: CW] = small_exp(small_in[(s*N+i)*SW +: SW]);
      else        r[l*CW +: CW] = full_in[((s-NS)*N+i)*CW +: CW];
    end
    return r;
  endfunction

  typedef struct {
    logic [2:0] sel;
    logic [3:0] rdy;      // out_ready pattern, bit k%4 used on cycle k
    bit         exp_err;
  } vec_t;

  // One request: start, optional overlapping start at beat ovl, optional
  // reset at beat rst_at, optional start during the DONE cycle.
  task automatic run(input logic [2:0] s, input logic [3:0] rdy, input bit exp_err,
                     input int ovl, input int rst_at, input bit start_in_done);
    int eb, k;
    @(negedge clk);
    sel = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sel = s ^ 3'd1;           // latched sel must be used from here on
    if (exp_err) begin
      chk("err_pulse", DW'(err), DW'(1));
      chk("err_no_valid", DW'(sif.out_valid), DW'(0));
      @(negedge clk);
      chk("err_one_cycle", DW'(err), DW'(0));
      chk("err_idle", DW'({sif.out_valid, busy}), DW'(0));
      return;
    end
    chk("first_valid", DW'({sif.out_valid, busy}), DW'(2'b11));
    eb = 0; k = 0;
    while (eb < BEATS && k < 400) begin
      sif.out_ready = rdy[k%4];
      k++;
      if (rst_at >= 0 && eb == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk("async_rst_out", DW'({sif.out_valid, busy, sif.out_last}), DW'(0));
        chk("async_rst_data", sif.out_data, '0);
        chk("async_rst_beat", DW'(sif.out_beat), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sif.out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", DW'({done, sif.out_valid, busy}), DW'(0));
        end
        return;
      end
      chk("valid", DW'(sif.out_valid), DW'(1));
      chk("beat", DW'(sif.out_beat), DW'(eb));
      chk("data", sif.out_data, exp_data(int'(s), eb));
      chk("last", DW'(sif.out_last), DW'(eb == BEATS-1));
      chk("no_done_mid", DW'(done), DW'(0));
      if (ovl >= 0 && eb == ovl) begin start = 1'b1; sel = (s == 3'd3) ? 3'd0 : 3'd3; end
      else start = 1'b0;
      if (sif.out_ready) eb++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("handshakes", DW'(eb), DW'(BEATS));
    if (rdy == 4'hF) chk("full_rate_cycles", DW'(k), DW'(BEATS));
    chk("done_pulse", DW'({done, sif.out_valid, busy}), DW'(3'b100));
    if (start_in_done) begin start = 1'b1; sel = 3'd0; end
    @(negedge clk);
    start = 1'b0;
    chk("after_done", DW'({done, sif.out_valid, busy, err}), DW'(0));
    @(negedge clk);
    chk("idle_stays", DW'({sif.out_valid, busy}), DW'(0));
  endtask

  initial begin
    vec_t vecs[7];
    logic [2:0] p5 [5];
    p5 = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd6};
    vecs[0] = '{3'd0, 4'b1111, 1'b0};
    vecs[1] = '{3'd4, 4'b1111, 1'b0};
    vecs[2] = '{3'd2, 4'b1001, 1'b0};
    vecs[3] = '{3'd1, 4'b0101, 1'b0};
    vecs[4] = '{3'd3, 4'b1111, 1'b0};
    vecs[5] = '{3'd5, 4'b1111, 1'b1};
    vecs[6] = '{3'd7, 4'b1111, 1'b1};

    for (int i = 0; i < N; i++) begin
      small_in[i*SW +: SW] = p5[i%5];
      for (int c = 1; c < NS; c++) small_in[(c*N+i)*SW +: SW] = 3'((i*3 + c) % 8);
      full_in[i*CW +: CW] = 12'(i*13);
    end
    sif.out_ready = 1'b1;

    // Async reset before any clock edge.
    #1 rst_n = 1'b0;
    #1 chk("reset_ctrl", DW'({sif.out_valid, sif.out_last, busy, done, err}), DW'(0));
    chk("reset_data", sif.out_data, '0);
    chk("reset_beat", DW'(sif.out_beat), DW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_start", DW'({sif.out_valid, busy, done, err}), DW'(0));
    end

    for (int v = 0; v < 7; v++) run(vecs[v].sel, vecs[v].rdy, vecs[v].exp_err, -1, -1, 1'b0);

    // Overlapping start mid-stream, then a start during the DONE cycle.
    run(3'd0, 4'hF, 1'b0, 4, -1, 1'b1);
    // Reset at beat 7, then a clean restart on channel 3.
    run(3'd1, 4'b1011, 1'b0, -1, 7, 1'b0);
    run(3'd3, 4'hF, 1'b0, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/poly_coeff_stream_mux.md
Name: poly_coeff_stream_mux

Overview:
- Parametrised successor to the combinational small/full polynomial selector feeding the encapsulation adder.
- Selects one of NUM_SMALL small-coefficient polynomials (error/noise, e.g. e_2, e_1[0..2]) or NUM_FULL full-width polynomials (e.g. msg_poly).
- Expands signed small coefficients to their mod-Q representative.
- Streams the result as LANES coefficients per beat over a valid/ready handshake, replacing the 768-wide flat output with a pipelined, back-pressurable stream.

Parameters:
- N, 256, coefficients per polynomial (KYBER_N).
- Q, 3329, modulus (KYBER_Q).
- SPOLY_WIDTH, 3, bits per small coefficient, two's complement.
- COEF_WIDTH, 12, bits per full coefficient (KYBER_R_WIDTH).
- NUM_SMALL, 4, number of small-polynomial channels.
- NUM_FULL, 1, number of full-polynomial channels.
- LANES, 16, coefficients emitted per beat; N mod LANES must be 0.
- SEL_W, 3, selector width; must satisfy 2^SEL_W >= NUM_SMALL+NUM_FULL.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; honoured only in IDLE
- sel  in  SEL_W  channel: 0..NUM_SMALL-1 small, NUM_SMALL..NUM_SMALL+NUM_FULL-1 full
- small_in  in  NUM_SMALL*N*SPOLY_WIDTH  packed small polys; channel c at [c*N*SPOLY_WIDTH +: N*SPOLY_WIDTH]; coefficient i at offset i*SPOLY_WIDTH
- full_in  in  NUM_FULL*N*COEF_WIDTH  packed full polys, same packing at COEF_WIDTH
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*COEF_WIDTH  coefficients beat*LANES .. beat*LANES+LANES-1; lane 0 in LSBs
- out_beat  out  $clog2(N/LANES)  index of the current beat
- out_last  out  1  high with the final beat
- busy  out  1  high from the cycle after an accepted start until the final handshake
- done  out  1  one-cycle pulse the cycle after the final handshake
- err  out  1  one-cycle pulse when start arrives with an out-of-range sel

Behaviour:
- Reset (async assert, sync deassert): state IDLE; out_valid, out_last, busy, done and err are 0; out_data and out_beat are 0.
- States are IDLE, STREAM and DONE.
- IDLE with start and a legal sel:
  - latch sel;
  - beat counter = 0;
  - next cycle: STREAM, busy=1, out_valid=1 carrying beat 0.
  - Latency from start to first valid is 1 cycle.
- IDLE with start and an illegal sel (>= NUM_SMALL+NUM_FULL): err=1 for one cycle, stay in IDLE, no beats emitted.
- STREAM:
  - out_data, out_beat and out_last are registered and held stable while out_valid && !out_ready.
  - On a handshake that is not the last beat, the next beat is presented the following cycle. Full throughput is 1 beat per cycle with out_ready tied high.
  - out_last = (beat == N/LANES-1).
  - Handshake on the last beat: out_valid=0, busy=0, go to DONE.
- DONE: done=1 for one cycle, then IDLE. start in this cycle is ignored.
- start while busy or in DONE is ignored; the latched sel is unchanged.
- Small-channel expansion, per coefficient v (signed, SPOLY_WIDTH bits):
  - v >= 0: zero-extend to COEF_WIDTH.
  - v < 0: output Q+v, so 3'b111 gives 3328 and 3'b110 gives 3327.
  - 3'b101 and 3'b100 map to 3326 and 3325. This is legal for generality; CBD eta=2 never produces them.
- Full channels pass through unmodified, with no reduction.
- small_in and full_in must be held stable by upstream while busy. They are sampled per beat, not captured at start.
- Mid-stream reset returns to IDLE immediately with out_valid=0. No done pulse is produced.

Decomposition:
- Add to the shared params package:
  - KYBER_Q, KYBER_N, KYBER_SPOLY_WIDTH, KYBER_R_WIDTH;
  - a state enum typedef (IDLE/STREAM/DONE);
  - a function small_to_modq(v) implementing the expansion rule, reusable by the NTT/adder paths.
- One natural sub-module: small_coeff_expand, a combinational LANES-wide expander. It takes LANES*SPOLY_WIDTH bits and returns LANES*COEF_WIDTH bits by instantiating small_to_modq per lane.
- FSM, beat counter and output register stay in the top.

Test Plan:
- Reset then idle: rst_n low mid-cycle forces out_valid=0 and busy=0 asynchronously; no activity with start=0.
- Small expansion with sel=0, small_in channel 0 coefficients cycling 0,1,2,7(-1),6(-2) and out_ready=1:
  - 16 beats on consecutive cycles, first valid 1 cycle after start;
  - lanes read 0,1,2,3328,3327 repeating;
  - out_last only on beat 15; done the cycle after.
- Full pass-through with sel=4 and full_in coefficient i = i*13:
  - every beat's lanes equal i*13 exactly;
  - beats 0..15 in order.
- Back-pressure with sel=2 and out_ready toggling 1,0,0,1 pseudo-randomly: out_data and out_beat stay constant while stalled; exactly 16 handshakes occur; no beat is duplicated or skipped.
- Illegal and overlapping start:
  - sel=5 gives an err pulse with no out_valid.
  - A second start during STREAM with a different sel does not alter the stream or the beat count.
- Reset mid-stream: deassert rst_n at beat 7, then restart with sel=3. A clean 16-beat stream starts at beat 0, with no done from the aborted run.
